l15_req_bridge: RTL and testbench

- Request-side decoupling stage between the core wrapper's flattened L1.5 request vector and the OpenPiton L1.5.
- Accepts core requests under a val/ack hold protocol and buffers them in a small FIFO.
- Re-issues them to the L1.5 under the same protocol, subject to a limit on outstanding transactions.
- Tracks in-flight requests and flags protocol underflow.

---
 rtl/l15_req_bridge_pkg.sv | 13 +
 rtl/l15_bridge_fifo.sv | 51 +++++
 rtl/l15_req_bridge.sv | 91 +++++++++
 tb/tb_l15_req_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l15_req_bridge_pkg.sv
// rtl/l15_req_bridge_pkg.sv - shared defaults and sizing helper for the L1.5 request bridge
package l15_req_bridge_pkg;

    localparam int L15_BRIDGE_REQ_W           = 256;
    localparam int L15_BRIDGE_DEPTH           = 4;
    localparam int L15_BRIDGE_MAX_OUTSTANDING = 8;

    // Counter must be able to hold MAX_OUTSTANDING itself, not just MAX_OUTSTANDING-1
    function automatic int l15_cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/l15_bridge_fifo.sv
// rtl/l15_bridge_fifo.sv - generic synchronous FIFO with wrap-bit full/empty and head data
module l15_bridge_fifo
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_l,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is cleared on reset so the head output reads zero until the first push
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/l15_req_bridge.sv
// rtl/l15_req_bridge.sv - core-to-L1.5 request decoupling FIFO with outstanding limit; optional L15_REQ_BRIDGE_BYPASS_EN
module l15_req_bridge
    import l15_req_bridge_pkg::*;
#(
    parameter int REQ_W           = L15_BRIDGE_REQ_W,
    parameter int DEPTH           = L15_BRIDGE_DEPTH,
    parameter int MAX_OUTSTANDING = L15_BRIDGE_MAX_OUTSTANDING,
    parameter int CNT_W           = l15_cnt_width(MAX_OUTSTANDING)
) (
    input  logic             clk_i,
    input  logic             reset_l,
    input  logic             core_req_val_i,
    input  logic [REQ_W-1:0] core_req_data_i,
    output logic             core_req_ack_o,
    output logic             l15_req_val_o,
    output logic [REQ_W-1:0] l15_req_data_o,
    input  logic             l15_req_ack_i,
    input  logic             rtrn_done_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o,
    output logic             err_o
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [REQ_W-1:0] fifo_head;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             credit_ok;
    logic             accept;
    logic             issue;

    assign credit_ok = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    // Reset gating keeps the ack quiet while reset_l is low even if the core holds val
    assign accept    = reset_l & core_req_val_i & ~fifo_full;
    assign issue     = l15_req_val_o & l15_req_ack_i;

`ifdef L15_REQ_BRIDGE_BYPASS_EN
    logic bypass_sel;

    assign bypass_sel     = reset_l & fifo_empty & credit_ok;
    assign l15_req_val_o  = bypass_sel ? core_req_val_i : (~fifo_empty & credit_ok);
    assign l15_req_data_o = bypass_sel ? core_req_data_i : fifo_head;
    assign fifo_push      = accept & ~(bypass_sel & l15_req_ack_i);
    assign fifo_pop       = issue & ~fifo_empty;
`else
    assign l15_req_val_o  = ~fifo_empty & credit_ok;
    assign l15_req_data_o = fifo_head;
    assign fifo_push      = accept;
    assign fifo_pop       = issue;
`endif

    assign core_req_ack_o = accept;

    l15_bridge_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_l (reset_l),
        .push    (fifo_push),
        .wdata   (core_req_data_i),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // A completion with nothing in flight is a protocol underflow: hold count, latch error
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (issue && !rtrn_done_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (!issue && rtrn_done_i) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;
    assign busy_o        = ~fifo_empty | (cnt_q != '0);

endmodule

// File: tb/tb_l15_req_bridge.sv
// tb/tb_l15_req_bridge.sv - self-checking bench for l15_req_bridge against a queue-based reference model
module tb_l15_req_bridge;

    localparam int REQ_W = 256;
    localparam int DEPTH = 4;
    localparam int MAXO  = 8;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             reset_l;
    logic             core_req_val_i;
    logic [REQ_W-1:0] core_req_data_i;
    logic             core_req_ack_o;
    logic             l15_req_val_o;
    logic [REQ_W-1:0] l15_req_data_o;
    logic             l15_req_ack_i;
    logic             rtrn_done_i;
    logic [CNT_W-1:0] outstanding_o;
    logic             busy_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    logic [REQ_W-1:0] m_q[$];
    int               m_cnt;
    bit               m_err;
    bit               src_pend;
    logic [REQ_W-1:0] src_data;

    l15_req_bridge #(
        .REQ_W           (REQ_W),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .reset_l         (reset_l),
        .core_req_val_i  (core_req_val_i),
        .core_req_data_i (core_req_data_i),
        .core_req_ack_o  (core_req_ack_o),
        .l15_req_val_o   (l15_req_val_o),
        .l15_req_data_o  (l15_req_data_o),
        .l15_req_ack_i   (l15_req_ack_i),
        .rtrn_done_i     (rtrn_done_i),
        .outstanding_o   (outstanding_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [REQ_W-1:0] obs, input logic [REQ_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] rand_req();
        logic [REQ_W-1:0] v;
        for (int i = 0; i < REQ_W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    // One clock: drive at negedge, check combinational view, advance model at posedge
    task automatic step(input bit la, input bit rd, input bit want_new);
        bit empty_m, full_m, exp_ack, exp_val, byp, issued;
        if (!src_pend && want_new) begin
            src_pend = 1'b1;
            src_data = rand_req();
        end
        core_req_val_i  = src_pend;
        core_req_data_i = src_data;
        l15_req_ack_i   = la;
        rtrn_done_i     = rd;
        #1;
        empty_m = (m_q.size() == 0);
        full_m  = (m_q.size() == DEPTH);
        exp_ack = src_pend && !full_m;
        byp     = 1'b0;
`ifdef L15_REQ_BRIDGE_BYPASS_EN
        byp     = empty_m && (m_cnt < MAXO);
`endif
        exp_val = byp ? src_pend : (!empty_m && (m_cnt < MAXO));
        chk("core_ack", core_req_ack_o, exp_ack);
        chk("l15_val", l15_req_val_o, exp_val);
        if (exp_val) chk("l15_data", l15_req_data_o, byp ? src_data : m_q[0]);
        chk("outstanding", outstanding_o, m_cnt);
        chk("busy", busy_o, (!empty_m || m_cnt != 0));
        chk("err", err_o, m_err);
        @(posedge clk_i);
        issued = exp_val && la;
        if (issued && !byp) void'(m_q.pop_front());
        if (exp_ack && !(byp && issued)) m_q.push_back(src_data);
        if (exp_ack) src_pend = 1'b0;
        if (issued && !rd) m_cnt++;
        else if (!issued && rd) begin
            if (m_cnt > 0) m_cnt--;
            else m_err = 1'b1;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        core_req_val_i  = 1'b1;
        core_req_data_i = '1;
        l15_req_ack_i   = 1'b1;
        rtrn_done_i     = 1'b0;
        reset_l         = 1'b0;
        #1;
        chk("rst_core_ack", core_req_ack_o, 0);
        chk("rst_l15_val", l15_req_val_o, 0);
        chk("rst_l15_data", l15_req_data_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        m_q.delete();
        m_cnt    = 0;
        m_err    = 1'b0;
        src_pend = 1'b0;
        @(negedge clk_i);
        core_req_val_i = 1'b0;
        l15_req_ack_i  = 1'b0;
        reset_l        = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (m_q.size() > 0 || m_cnt > 0 || src_pend); i++) begin
            step(1'b1, m_cnt > 0, 1'b0);
        end
        chk("drain_busy", busy_o, 0);
    endtask

    initial begin
        reset_l         = 1'b0;
        core_req_val_i  = 1'b0;
        core_req_data_i = '0;
        l15_req_ack_i   = 1'b0;
        rtrn_done_i     = 1'b0;
        src_pend        = 1'b0;
        src_data        = '0;
        m_cnt           = 0;
        m_err           = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Single request: ack cycle 0, visible cycle 1, L1.5 ack cycle 3, then completion
        src_pend = 1'b1;
        src_data = {32{8'hA5}};
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("single_outstanding", outstanding_o, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("single_idle_cnt", outstanding_o, 0);
        chk("single_idle_busy", busy_o, 0);

        // Fill: four accepted, fifth held until the cycle after the first pop
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        drain();

        // Throttle at MAX_OUTSTANDING, release by one completion
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1);
        chk("throttle_cnt", outstanding_o, MAXO);
        chk("throttle_val_low", l15_req_val_o, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("throttle_val_back", l15_req_val_o, 1);
        step(1'b1, 1'b0, 1'b1);
        chk("throttle_ninth", outstanding_o, MAXO);
        drain();

        // Pop with simultaneous completion at cnt 3, then underflow
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("cnt_three", outstanding_o, 3);
        step(1'b1, 1'b1, 1'b0);
        chk("pop_done_hold", outstanding_o, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        chk("cnt_zero", outstanding_o, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("underflow_err", err_o, 1);
        chk("underflow_cnt", outstanding_o, 0);
        step(1'b0, 1'b0, 1'b0);

        // Reset with 3 buffered and 5 in flight
        do_reset();
        for (int i = 0; i < 30 && m_cnt < 5; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 30 && m_q.size() < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("pre_rst_cnt", outstanding_o, 5);
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_val", l15_req_val_o, 0);
        chk("post_rst_busy", busy_o, 0);

`ifdef L15_REQ_BRIDGE_BYPASS_EN
        // Bypass: empty FIFO, core val and L1.5 ack together
        src_pend = 1'b1;
        src_data = rand_req();
        step(1'b1, 1'b0, 1'b0);
        chk("bypass_cnt", outstanding_o, 1);
        step(1'b0, 1'b0, 1'b0);
        drain();
`endif

        // Randomized traffic in phases of varying completion pressure
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            int done_pct;
            done_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 40 : 75);
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 3) != 0,
                     (m_cnt > 0) && ($urandom_range(0, 99) < done_pct),
                     $urandom_range(0, 3) != 0);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
